// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store bus controller.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return (off[0] == 1'b0);
      SZ_W:    return (off[1:0] == 2'b00);
      default: return (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store data/strobe placement and load shift with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [2:0]  st_off_i,
  input  logic [63:0] st_data_i,
  input  logic [1:0]  ld_size_i,
  input  logic [2:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [63:0] ld_rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] ld_data_o
);

  logic [63:0] shifted;

  assign wdata_o = st_data_i << {st_off_i, 3'b000};
  assign wstrb_o = size_mask(st_size_i) << st_off_i;

  always_comb begin
    shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = shifted;
    case (ld_size_i)
      SZ_B: ld_data_o = ld_unsigned_i ? {56'b0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data_o = ld_unsigned_i ? {48'b0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: ld_data_o = ld_unsigned_i ? {32'b0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one aligned access per req/gnt/rvalid transaction,
// with a bounded wait and a single-cycle completion pulse back to the mem stage.
//   state | meaning
//   IDLE  | waiting for ce; checks alignment
//   REQ   | bus_req held, fields stable, waiting for bus_gnt
//   RESP  | granted, waiting for bus_rvalid
//   DONE  | data_mem_ready pulse with data and error flags
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        data_mem_rw,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic [63:0] mem_data,
  output logic [7:0]  mem_data_byte_valid,
  output logic        data_mem_ready,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]  size_q, size_d;
  logic [2:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] baddr_q, baddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] mdata_q, mdata_d;
  logic [7:0]  bv_q, bv_d;
  logic        rdy_q, rdy_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        fin, tmo;
  logic [63:0] al_wdata, al_ld;
  logic [7:0]  al_wstrb;

  lsu_align u_align (
    .st_size_i     (size),
    .st_off_i      (addr[2:0]),
    .st_data_i     (store_data),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (bus_rdata),
    .wdata_o       (al_wdata),
    .wstrb_o       (al_wstrb),
    .ld_data_o     (al_ld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    req_d   = req_q;
    we_d    = we_q;
    baddr_d = baddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mdata_d = '0;
    bv_d    = '0;
    rdy_d   = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ce) begin
          size_d = size;
          off_d  = addr[2:0];
          uns_d  = load_unsigned;
          if (is_aligned(size, addr[2:0])) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = data_mem_rw;
            baddr_d = {addr[63:3], 3'b000};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
          end else begin
            state_d = DONE;
            rdy_d   = 1'b1;
            mis_d   = 1'b1;
            bv_d    = size_mask(size);
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (bus_gnt && bus_rvalid) begin
          fin = 1'b1;
        end else if (cnt_inc == CNT_MAX) begin
          tmo = 1'b1;
        end else if (bus_gnt) begin
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_inc;
        if (bus_rvalid) begin
          fin = 1'b1;
        end else if (cnt_inc == CNT_MAX) begin
          tmo = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A real response wins over a timeout landing on the same edge.
    if (fin || tmo) begin
      state_d = DONE;
      req_d   = 1'b0;
      rdy_d   = 1'b1;
      err_d   = tmo;
      bv_d    = size_mask(size_q);
      mdata_d = (fin && !we_q) ? al_ld : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mdata_q <= '0;
      bv_q    <= '0;
      rdy_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      mdata_q <= mdata_d;
      bv_q    <= bv_d;
      rdy_q   <= rdy_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign mem_data            = mdata_q;
  assign mem_data_byte_valid = bv_q;
  assign data_mem_ready      = rdy_q;
  assign misaligned          = mis_q;
  assign bus_err             = err_q;
  assign bus_req             = req_q;
  assign bus_we              = we_q;
  assign bus_addr            = baddr_q;
  assign bus_wdata           = wdata_q;
  assign bus_wstrb           = wstrb_q;

endmodule
